// File: rtl/nrv_mem_pkg.sv
// ----------------------------------------------------------------------------
// nrv_mem_pkg
// Shared types and constants for the data-memory request/response path.
//
// Contents:
//   mem_req_t        : decoded request {addr, wdata, be, we}
//   mem_rsp_t        : response beat {valid, rdata}
//   PIN_ADDR         : byte address of the optional pin register
//                      (only decoded when DMEM_PIN_REG_EN is defined)
//   DEFAULT_ERR_DATA : read data returned for out-of-range reads
//   merge_byte_lanes : byte-enable merge of new write data onto an old word
// ----------------------------------------------------------------------------
package nrv_mem_pkg;

    localparam logic [31:0] PIN_ADDR         = 32'h0000_8000;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } mem_rsp_t;

    // Replace each byte of old_word whose enable bit is set with the
    // matching byte of new_word; lane i covers bits [8i+7:8i].
    function automatic logic [31:0] merge_byte_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rsp_delay_pipe.sv
// ----------------------------------------------------------------------------
// rsp_delay_pipe
// LATENCY-stage shift register carrying a valid bit and a data word.
// A beat entering on in_valid appears on out_valid exactly LATENCY clocks
// later. Data of an empty stage is held at zero so the output word is zero
// whenever out_valid is low.
//
// Ports:
//   clock     : system clock
//   flush     : synchronous clear of every stage (valid and data)
//   in_valid  : beat strobe into stage 0
//   in_data   : beat data into stage 0
//   out_valid : valid bit of the last stage
//   out_data  : data of the last stage (zero when out_valid is low)
// ----------------------------------------------------------------------------
module rsp_delay_pipe #(
    parameter int LATENCY = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clock,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Shift every stage forward by one each clock; flush wins over the
    // incoming beat so a beat presented together with flush is discarded.
    always_ff @(posedge clock) begin
        if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/dmem_latency_responder.sv
// ----------------------------------------------------------------------------
// dmem_latency_responder
// Memory-side responder for the core's data-memory req/rsp interface.
// Every cycle with io_req_valid high accepts one request (no backpressure).
// Writes update a word array per byte lane at the accepting edge; reads
// sample the array at the accepting edge. Exactly one response per request
// comes back LATENCY cycles after acceptance, in order. Accesses outside
// [BASE_ADDR, BASE_ADDR + DEPTH*4) drop writes, return ERR_DATA for reads,
// and set the sticky io_err flag.
//
// Optional feature (macro DMEM_PIN_REG_EN):
//   Adds a 32-bit output register io_pin at byte address PIN_ADDR.
//   Writes there merge into io_pin per byte lane, reads return io_pin, and
//   the address is never treated as out of range. Without the macro the
//   port does not exist and PIN_ADDR decodes like any other address.
//
// Ports:
//   clock                      : system clock
//   reset                      : synchronous, active-high reset
//   io_req_valid               : request strobe
//   io_req_bits_addrRequest    : byte address (bits [1:0] ignored)
//   io_req_bits_dataRequest    : write data
//   io_req_bits_activeByteLane : write byte enables
//   io_req_bits_isWrite        : 1 = write, 0 = read
//   io_rsp_valid               : one-cycle response strobe
//   io_rsp_bits_dataResponse   : read data, 0 for writes and idle cycles
//   io_err                     : sticky out-of-range flag
//   io_pin                     : pin register (DMEM_PIN_REG_EN only)
// ----------------------------------------------------------------------------
module dmem_latency_responder
    import nrv_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    input  logic [31:0] io_req_bits_addrRequest,
    input  logic [31:0] io_req_bits_dataRequest,
    input  logic [3:0]  io_req_bits_activeByteLane,
    input  logic        io_req_bits_isWrite,
    output logic        io_rsp_valid,
    output logic [31:0] io_rsp_bits_dataResponse,
    output logic        io_err
`ifdef DMEM_PIN_REG_EN
    ,
    output logic [31:0] io_pin
`endif
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

    mem_req_t         req;
    mem_rsp_t         rsp_in;
    mem_rsp_t         rsp_out;
    logic [31:0]      offset;
    logic             in_range;
    logic             pin_hit;
    logic             mem_hit;
    logic             out_of_range;
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      pin_value;
    logic [31:0]      mem [DEPTH];

    assign req = '{addr:  io_req_bits_addrRequest,
                   wdata: io_req_bits_dataRequest,
                   be:    io_req_bits_activeByteLane,
                   we:    io_req_bits_isWrite};

    // A request presented while reset is high is ignored entirely.
    assign accept = io_req_valid && !reset;

    // Range check: the >= test rules out underflow of the subtraction, and
    // the 33-bit compare keeps BASE_ADDR + DEPTH*4 from wrapping.
    assign offset   = req.addr - BASE_ADDR;
    assign in_range = (req.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
    assign word_idx = offset[IDX_W+1:2];

`ifdef DMEM_PIN_REG_EN
    assign pin_hit   = (req.addr[31:2] == PIN_ADDR[31:2]);
    assign pin_value = io_pin;
`else
    assign pin_hit   = 1'b0;
    assign pin_value = 32'h0;
`endif

    // The pin register shadows the array if PIN_ADDR happens to fall inside
    // it, and is never reported as an error.
    assign mem_hit      = in_range && !pin_hit;
    assign out_of_range = !in_range && !pin_hit;

    // Array write at the accepting edge. A read in the following cycle sees
    // the new contents because the array is read combinationally below.
    always_ff @(posedge clock) begin
        if (accept && req.we && mem_hit) begin
            mem[word_idx] <= merge_byte_lanes(mem[word_idx], req.wdata, req.be);
        end
    end

    // Response data sampled at the accepting edge: writes answer with zero,
    // reads pick the pin register, the array, or the error pattern.
    always_comb begin
        rsp_in = '{valid: io_req_valid, rdata: 32'h0};
        if (!req.we) begin
            if (pin_hit) begin
                rsp_in.rdata = pin_value;
            end else if (mem_hit) begin
                rsp_in.rdata = mem[word_idx];
            end else begin
                rsp_in.rdata = ERR_DATA;
            end
        end
    end

    // Fixed-latency delay line; reset doubles as the flush so in-flight
    // responses are dropped and a request arriving with reset never enters.
    rsp_delay_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (32)
    ) u_rsp_delay_pipe (
        .clock     (clock),
        .flush     (reset),
        .in_valid  (rsp_in.valid),
        .in_data   (rsp_in.rdata),
        .out_valid (rsp_out.valid),
        .out_data  (rsp_out.rdata)
    );

    // The last pipe stage is only cleared at the reset edge, so a response
    // that is already due in the reset cycle is masked here; nothing leaves
    // the block while reset is high.
    assign io_rsp_valid             = rsp_out.valid && !reset;
    assign io_rsp_bits_dataResponse = reset ? 32'h0 : rsp_out.rdata;

    // Sticky error flag, set on the edge that accepts an out-of-range access.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_err <= 1'b0;
        end else if (io_req_valid && out_of_range) begin
            io_err <= 1'b1;
        end
    end

`ifdef DMEM_PIN_REG_EN
    // Pin register write, merged per byte lane like an array word.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_pin <= 32'h0;
        end else if (io_req_valid && req.we && pin_hit) begin
            io_pin <= merge_byte_lanes(io_pin, req.wdata, req.be);
        end
    end
`endif

endmodule
